// File: rtl/branch_resolve_unit.sv
// Branch resolve unit: decodes the 3-bit branch conditions and trains a PC-indexed 2-bit predictor.
// Latency: one cycle from a sampled branch to res_valid_o/taken_o/mispredict_o; pred_taken_o is combinational.
// Backpressure: stall_i freezes every register and blocks training; stall_i wins over flush_i. Optional stats: BRU_STATS_EN.
module branch_resolve_unit #(
  parameter int DW    = 32,
  parameter int PC_W  = 32,
  parameter int IDX_W = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            stall_i,
  input  logic            flush_i,
  input  logic [PC_W-1:0] fpc_i,
  output logic            pred_taken_o,
  input  logic            valid_i,
  input  logic [2:0]      op_i,
  input  logic [DW-1:0]   a_i,
  input  logic [DW-1:0]   b_i,
  input  logic [PC_W-1:0] pc_i,
  input  logic            pred_i,
  output logic            res_valid_o,
  output logic            taken_o,
  output logic            mispredict_o
`ifdef BRU_STATS_EN
  ,
  output logic [31:0]     br_cnt_o,
  output logic [31:0]     mp_cnt_o
`endif
);

  localparam int ENTRIES = 1 << IDX_W;

  localparam logic [2:0] OP_BEQ  = 3'b000;
  localparam logic [2:0] OP_BNE  = 3'b001;
  localparam logic [2:0] OP_BGEZ = 3'b010;
  localparam logic [2:0] OP_BGTZ = 3'b011;
  localparam logic [2:0] OP_BLEZ = 3'b100;
  localparam logic [2:0] OP_BLTZ = 3'b101;
  localparam logic [2:0] OP_BLT  = 3'b110;
  localparam logic [2:0] OP_BLTU = 3'b111;

  // Word-aligned index; low two bits and bits above the index are don't-care.
  logic [IDX_W-1:0] widx;
  logic [IDX_W-1:0] ridx;
  assign widx = pc_i[IDX_W+1:2];
  assign ridx = fpc_i[IDX_W+1:2];

  logic unused_pc_bits;
  assign unused_pc_bits = ^{pc_i[PC_W-1:IDX_W+2], pc_i[1:0],
                            fpc_i[PC_W-1:IDX_W+2], fpc_i[1:0]};

  logic a_neg;
  logic a_zero;
  assign a_neg  = a_i[DW-1];
  assign a_zero = (a_i == '0);

  logic cond;

  // Fully decoded branch condition; the zero-compare ops look only at a_i.
  always_comb begin
    cond = 1'b0;
    case (op_i)
      OP_BEQ:  cond = (a_i == b_i);
      OP_BNE:  cond = (a_i != b_i);
      OP_BGEZ: cond = ~a_neg;
      OP_BGTZ: cond = ~a_neg & ~a_zero;
      OP_BLEZ: cond = a_neg | a_zero;
      OP_BLTZ: cond = a_neg;
      OP_BLT:  cond = ($signed(a_i) < $signed(b_i));
      OP_BLTU: cond = (a_i < b_i);
      default: cond = 1'b0;
    endcase
  end

  // A branch "fires" when it is accepted this edge: it reports and trains.
  logic fire;
  logic mp_now;
  assign fire   = ~stall_i & valid_i & ~flush_i;
  assign mp_now = fire & (cond != pred_i);

  logic [1:0] cnt_q [ENTRIES];
  logic [1:0] cnt_upd;

  // Saturating step of the entry addressed by the resolving branch.
  always_comb begin
    cnt_upd = cnt_q[widx];
    if (cond) begin
      if (cnt_q[widx] != 2'b11) cnt_upd = cnt_q[widx] + 2'b01;
    end else begin
      if (cnt_q[widx] != 2'b00) cnt_upd = cnt_q[widx] - 2'b01;
    end
  end

  // Prediction table: reset to weakly not-taken, one write per accepted branch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) cnt_q[i] <= 2'b01;
    end else if (fire) begin
      cnt_q[widx] <= cnt_upd;
    end
  end

  // Read the registered table directly, so a same-cycle update is not visible yet.
  assign pred_taken_o = cnt_q[ridx][1];

  logic res_valid_q, res_valid_d;
  logic taken_q, taken_d;
  logic mp_q, mp_d;

  // Next outcome state; stall holds, otherwise outcome bits are gated by acceptance.
  always_comb begin
    res_valid_d = res_valid_q;
    taken_d     = taken_q;
    mp_d        = mp_q;
    if (!stall_i) begin
      res_valid_d = fire;
      taken_d     = fire & cond;
      mp_d        = mp_now;
    end
  end

  // Outcome registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_valid_q <= 1'b0;
      taken_q     <= 1'b0;
      mp_q        <= 1'b0;
    end else begin
      res_valid_q <= res_valid_d;
      taken_q     <= taken_d;
      mp_q        <= mp_d;
    end
  end

  assign res_valid_o  = res_valid_q;
  assign taken_o      = taken_q;
  assign mispredict_o = mp_q;

`ifdef BRU_STATS_EN
  logic [31:0] br_cnt_q, br_cnt_d;
  logic [31:0] mp_cnt_q, mp_cnt_d;

  // Free-running event counters; natural 32-bit wrap.
  always_comb begin
    br_cnt_d = br_cnt_q;
    mp_cnt_d = mp_cnt_q;
    if (fire)   br_cnt_d = br_cnt_q + 32'd1;
    if (mp_now) mp_cnt_d = mp_cnt_q + 32'd1;
  end

  // Statistics registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      br_cnt_q <= 32'd0;
      mp_cnt_q <= 32'd0;
    end else begin
      br_cnt_q <= br_cnt_d;
      mp_cnt_q <= mp_cnt_d;
    end
  end

  assign br_cnt_o = br_cnt_q;
  assign mp_cnt_o = mp_cnt_q;
`endif

endmodule
